// File: rtl/channel_monitor_pkg.sv
// Shared widths and helpers for the channel monitor.
// CHANNEL_MONITOR_TIMESTAMP_EN prepends a cycle timestamp to every record.
package channel_monitor_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_TS_WIDTH   = 16;
  localparam int unsigned DEF_DROP_WIDTH = 8;

`ifdef CHANNEL_MONITOR_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  function automatic int unsigned mon_width(input int unsigned data_w,
                                            input int unsigned ts_w,
                                            input bit          ts_en);
    return ts_en ? (ts_w + data_w) : data_w;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/monitor_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted when a pop
// retires the head in the same cycle.
module monitor_fifo
  import channel_monitor_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = count_width(DEPTH),
  localparam int unsigned PTR_W = CNT_W - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally since DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/channel_monitor_fifo.sv
// Passive ready-valid channel tap buffering fired transfers for a monitor port.
// CHANNEL_MONITOR_TIMESTAMP_EN adds a free-running timestamp in the record MSBs.
module channel_monitor_fifo
  import channel_monitor_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned TS_WIDTH   = DEF_TS_WIDTH,
  parameter  int unsigned DROP_WIDTH = DEF_DROP_WIDTH,
  localparam int unsigned MON_WIDTH  = mon_width(DATA_WIDTH, TS_WIDTH, TS_EN),
  localparam int unsigned CNT_WIDTH  = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tap_valid,
  input  logic                  tap_ready,
  input  logic [DATA_WIDTH-1:0] tap_data,
  input  logic                  monitor_ready,
  output logic                  monitor_valid,
  output logic [MON_WIDTH-1:0]  monitor_data,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  overflow,
  output logic [DROP_WIDTH-1:0] drop_count
);

  logic                  fire, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [MON_WIDTH-1:0]  record;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

`ifdef CHANNEL_MONITOR_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  assign ts_d = ts_q + TS_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  assign record = {ts_q, tap_data};
`else
  assign record = tap_data;
`endif

  assign fire = tap_valid & tap_ready;
  assign pop  = monitor_valid & monitor_ready;
  // A full FIFO only loses the record when nothing leaves this cycle.
  assign drop = fire & fifo_full & ~pop;

  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  monitor_fifo #(
    .WIDTH (MON_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fire),
    .data_i  (record),
    .pop_i   (pop),
    .data_o  (monitor_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign monitor_valid = ~fifo_empty;
  assign overflow      = overflow_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_channel_monitor_fifo.sv
// Directed self-checking bench for channel_monitor_fifo (default parameters).
module tb_channel_monitor_fifo;

`ifdef CHANNEL_MONITOR_TIMESTAMP_EN
  localparam int unsigned MW = 24;
`else
  localparam int unsigned MW = 8;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tap_valid, tap_ready, monitor_ready;
  logic [7:0]    tap_data;
  logic          monitor_valid;
  logic [MW-1:0] monitor_data;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic [7:0]    drop_count;

  int checks = 0;
  int errors = 0;

  channel_monitor_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .TS_WIDTH   (16),
    .DROP_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tap_valid     (tap_valid),
    .tap_ready     (tap_ready),
    .tap_data      (tap_data),
    .monitor_ready (monitor_ready),
    .monitor_valid (monitor_valid),
    .monitor_data  (monitor_data),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // Expected record: {ts, data}, truncated to data alone without timestamps.
  function automatic logic [MW-1:0] rec(input logic [15:0] ts, input logic [7:0] d);
    logic [23:0] full;
    full = {ts, d};
    return MW'(full);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first non-reset cycle (timestamp 0).
  task automatic do_reset();
    rst = 1'b1; tap_valid = 1'b0; tap_ready = 1'b0; tap_data = '0; monitor_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (monitor_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", monitor_valid); end
    checks++; if (monitor_data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", monitor_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
  endtask

  task automatic test_single();
    do_reset();
    step(); step(); step();
    tap_valid = 1'b1; tap_ready = 1'b1; tap_data = 8'hA5; monitor_ready = 1'b1;
    step();
    tap_valid = 1'b0;
    checks++; if (monitor_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", monitor_valid); end
    checks++; if (monitor_data !== rec(16'd3, 8'hA5)) begin errors++; $display("FAIL single_data got %0h want %0h", monitor_data, rec(16'd3, 8'hA5)); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", fifo_count); end
    step();
    checks++; if (monitor_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", monitor_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      tap_valid = 1'b1; tap_ready = 1'b1; tap_data = 8'(i);
      step();
    end
    tap_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
    monitor_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (monitor_data !== rec(16'(i), 8'(i + 1))) begin errors++; $display("FAIL ovf_drain%0d got %0h want %0h", i, monitor_data, rec(16'(i), 8'(i + 1))); end
      step();
    end
    checks++; if (monitor_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b want 0", monitor_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    logic [MW-1:0] exp_q [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tap_valid = 1'b1; tap_ready = 1'b1; tap_data = 8'(8'h10 + i);
      step();
    end
    tap_data = 8'h20; monitor_ready = 1'b1;
    step();
    tap_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_count got %0d want 4", fifo_count); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL fullpop_drop got %0d want 0", drop_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %0b want 0", overflow); end
    exp_q[0] = rec(16'd1, 8'h11);
    exp_q[1] = rec(16'd2, 8'h12);
    exp_q[2] = rec(16'd3, 8'h13);
    exp_q[3] = rec(16'd4, 8'h20);
    for (int i = 0; i < 4; i++) begin
      checks++; if (monitor_data !== exp_q[i]) begin errors++; $display("FAIL fullpop_drain%0d got %0h want %0h", i, monitor_data, exp_q[i]); end
      step();
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL fullpop_empty got %0d want 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    monitor_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tap_valid = 1'b1; tap_ready = 1'b1; tap_data = 8'(8'h30 + i);
      step();
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count%0d got %0d want 1", i, fifo_count); end
      checks++; if (monitor_data !== rec(16'(i), 8'(8'h30 + i))) begin errors++; $display("FAIL b2b_data%0d got %0h want %0h", i, monitor_data, rec(16'(i), 8'(8'h30 + i))); end
    end
    tap_valid = 1'b0;
    step();
  endtask

  task automatic test_no_ready();
    do_reset();
    tap_valid = 1'b1; tap_ready = 1'b0; tap_data = 8'h5A;
    for (int i = 0; i < 5; i++) step();
    tap_valid = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL noready_count got %0d want 0", fifo_count); end
    checks++; if (monitor_valid !== 1'b0) begin errors++; $display("FAIL noready_valid got %0b want 0", monitor_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    tap_valid = 1'b1; tap_ready = 1'b1; tap_data = 8'hC3;
    for (int i = 0; i < 104; i++) step();
    checks++; if (drop_count !== 8'd100) begin errors++; $display("FAIL sat_mid got %0d want 100", drop_count); end
    for (int i = 0; i < 200; i++) step();
    tap_valid = 1'b0;
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", drop_count); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL sat_count got %0d want 4", fifo_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tap_valid = 1'b1; tap_ready = 1'b1; tap_data = 8'(8'h40 + i);
      step();
    end
    tap_valid = 1'b0; monitor_ready = 1'b1;
    step();
    monitor_ready = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", fifo_count); end
    rst = 1'b1; tap_valid = 1'b1; tap_ready = 1'b1; tap_data = 8'hEE;
    step();
    checks++; if (monitor_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", monitor_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %0b want 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_drop got %0d want 0", drop_count); end
    rst = 1'b0; tap_data = 8'h77;
    step();
    tap_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mid_after_count got %0d want 1", fifo_count); end
    checks++; if (monitor_data !== rec(16'd0, 8'h77)) begin errors++; $display("FAIL mid_ts_restart got %0h want %0h", monitor_data, rec(16'd0, 8'h77)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_no_ready();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
